fft_scan: RTL and testbench
===========================

FFT_SCAN -- requirements
Module: fft_scan

Interface
REQ-001 SHALL have parameter RN, default 16, bin/sample word width.
REQ-002 SHALL have parameter SIZE, default 32, bins per frame; power of two, 4..32.
REQ-003 SHALL have parameter PERIOD, default 1024, cycles between capture attempts; minimum SIZE+4.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port n_reset  in  1  synchronous active-low reset.
REQ-006 SHALL have port en  in  1  enables capture attempts; level.
REQ-007 SHALL have port shift  out  1  to FFT: 0 latches spectrum, 1 shifts bin chain.
REQ-008 SHALL have port fft_data  in  RN  from FFT: |re|+|im| of head bin, 1-cycle registered.
REQ-009 SHALL have port bin_data  out  RN  buffered bin magnitude.
REQ-010 SHALL have port bin_idx  out  $clog2(SIZE)  bin number of bin_data.
REQ-011 SHALL have port bin_sof / bin_eof  out  1 each  qualify bin 0 / bin SIZE-1.
REQ-012 SHALL have port bin_valid  out  1  and bin_ready  in  1  valid/ready stream handshake.
REQ-013 SHALL have port frame_drop  out  1  one-cycle pulse when a capture attempt is skipped.
REQ-014 SHALL have port busy  out  1  high from CAPTURE until last bin is written.

Function
REQ-015 SHALL run a period counter 0..PERIOD-1 while en=1, wrapping; attempt fires at count PERIOD-1.
REQ-016 SHALL have states IDLE, CAPTURE, WAIT, FILL.
REQ-017 IDLE->CAPTURE on attempt when the buffer is empty; on attempt with buffer non-empty or state not IDLE, SHALL stay and pulse frame_drop.
REQ-018 CAPTURE SHALL last exactly 1 cycle with shift=0; shift SHALL be 1 in every other state and cycle.
REQ-019 CAPTURE->WAIT (1 cycle)->FILL; FILL SHALL last exactly SIZE cycles, writing fft_data to the buffer each cycle with bin index 0..SIZE-1, then ->IDLE.
REQ-020 If CAPTURE occurs at cycle T, bin k SHALL be written from fft_data sampled at cycle T+2+k.
REQ-021 Buffer SHALL be a SIZE-entry FIFO; bin_valid = not empty; pop when bin_valid && bin_ready; read may overlap FILL.
REQ-022 Push and pop in one cycle SHALL both occur; the FIFO never overflows, because capture requires empty.
REQ-023 bin_data/bin_idx/sof/eof SHALL hold stable while bin_valid && !bin_ready.
REQ-024 en falling mid-frame SHALL let the frame complete; en=0 SHALL clear the period counter to 0.

Reset
REQ-025 n_reset=0 at a posedge SHALL force IDLE, counter=0, FIFO empty.
REQ-026 Reset output values: shift=1, bin_valid=0, frame_drop=0, busy=0, bin_data=0, bin_idx=0, sof=eof=0.
REQ-027 Reset mid-FILL SHALL discard the partial frame; no bins are presented after release.

Configuration
REQ-028 Macro FFT_SCAN_PEAK_EN: when defined, SHALL add outputs peak_val (RN), peak_idx ($clog2(SIZE)) and peak_valid (1).
REQ-029 With FFT_SCAN_PEAK_EN, SHALL track the max fft_data over FILL, using strict greater-than so the lowest index wins ties.
REQ-030 With FFT_SCAN_PEAK_EN, SHALL pulse peak_valid for 1 cycle after the last FILL cycle, holding peak_val/idx until the next frame; all are reset to 0.
REQ-031 Without FFT_SCAN_PEAK_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package fft_pkg SHALL hold the state enum fft_scan_state_t and a bin-record typedef {data, idx, sof, eof}.
REQ-033 The FIFO SHALL be sub-module fft_scan_fifo (parameters RN, SIZE; push/pop/empty/full); the FSM and counter stay in fft_scan.

Verification (SIZE=8, RN=16, PERIOD=32)
REQ-034 en=1, bin_ready=1, fft_data=cycle count: shift low at cycle 31 only, bins 0..7 = data sampled at 33..40, sof on bin 0, eof on bin 7.
REQ-035 bin_ready=0 for 100 cycles: 8 bins are held, frame_drop pulses at counts 63 and 95, no overwrite, and the bins drain intact on ready.
REQ-036 n_reset low during FILL at bin 3: after release bin_valid=0 and the next frame starts fresh at the next attempt.
REQ-037 bin_ready toggling 1,0 each cycle: the data/idx sequence is unchanged with no duplicates or losses.
REQ-038 FFT_SCAN_PEAK_EN, bins {5,9,2,9,1,0,3,4}: peak_val=9, peak_idx=1, peak_valid pulses once.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types for the FFT bin scanner: controller state encoding and the
// record carried through the bin buffer.
package fft_pkg;

    // Upper bounds on bin word width and bin index width carried in a record.
    // Instances use the low RN / $clog2(SIZE) bits; SIZE tops out at 32.
    localparam int FFT_RN_MAX  = 32;
    localparam int FFT_IDX_MAX = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2,
        ST_FILL    = 2'd3
    } fft_scan_state_t;

    typedef struct packed {
        logic [FFT_RN_MAX-1:0]  data;
        logic [FFT_IDX_MAX-1:0] idx;
        logic                   sof;
        logic                   eof;
    } bin_rec_t;

endpackage

// File: rtl/fft_scan_fifo.sv
// SIZE-entry bin buffer. Stores only the significant RN + $clog2(SIZE) + 2
// bits of each record; the read record reads as all-zero while empty.
module fft_scan_fifo
    import fft_pkg::*;
#(
    parameter int RN   = 16,
    parameter int SIZE = 32
) (
    input  logic     clk,
    input  logic     n_reset,
    input  logic     push,
    input  bin_rec_t wr_rec,
    input  logic     pop,
    output bin_rec_t rd_rec,
    output logic     empty,
    output logic     full
);

    localparam int AW = $clog2(SIZE);
    localparam int EW = RN + AW + 2;

    logic [EW-1:0] mem_q [SIZE];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    logic [EW-1:0] rd_entry;
    logic          unused_wr;

    // Only the low bits of the wide record are stored.
    assign unused_wr = ^wr_rec;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(SIZE));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy next-state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment only, so every
        // flop samples the pre-edge values regardless of statement order.
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; the empty flag masks
        // stale contents, and leaving it reset-free keeps it mappable to RAM.
        if (do_push) begin
            mem_q[wr_ptr_q] <= {wr_rec.data[RN-1:0], wr_rec.idx[AW-1:0],
                                wr_rec.sof, wr_rec.eof};
        end
    end

    // Head-of-queue record, forced to zero while empty.
    always_comb begin
        rd_entry = mem_q[rd_ptr_q];
        rd_rec   = '0;
        if (!empty) begin
            rd_rec.data[RN-1:0] = rd_entry[EW-1 -: RN];
            rd_rec.idx[AW-1:0]  = rd_entry[2 +: AW];
            rd_rec.sof          = rd_entry[1];
            rd_rec.eof          = rd_entry[0];
        end
    end

endmodule

// File: rtl/fft_scan.sv
// Periodic spectrum scanner: every PERIOD cycles latches the FFT spectrum,
// shifts the SIZE bins out of the FFT chain into a buffer and streams them
// out over a valid/ready interface. An attempt that finds the controller
// busy or the buffer non-empty is dropped and flagged on frame_drop.
// Optional FFT_SCAN_PEAK_EN adds per-frame peak bin reporting.
module fft_scan
    import fft_pkg::*;
#(
    parameter int RN     = 16,
    parameter int SIZE   = 32,
    parameter int PERIOD = 1024
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    en,
    output logic                    shift,
    input  logic [RN-1:0]           fft_data,
    output logic [RN-1:0]           bin_data,
    output logic [$clog2(SIZE)-1:0] bin_idx,
    output logic                    bin_sof,
    output logic                    bin_eof,
    output logic                    bin_valid,
    input  logic                    bin_ready,
    output logic                    frame_drop,
    output logic                    busy
`ifdef FFT_SCAN_PEAK_EN
    ,
    output logic [RN-1:0]           peak_val,
    output logic [$clog2(SIZE)-1:0] peak_idx,
    output logic                    peak_valid
`endif
);

    localparam int IW = $clog2(SIZE);
    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [IW-1:0] BIN_LAST = IW'(SIZE - 1);

    fft_scan_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   fill_idx_q, fill_idx_d;
    logic            frame_drop_q, frame_drop_d;
    logic            attempt;
    logic            push, pop;
    logic            fifo_empty, fifo_full;
    bin_rec_t        wr_rec, rd_rec;
    logic            unused_top;

    // Counter and controller next-state. The attempt is decoded on the
    // edge that loads count PERIOD-1, so CAPTURE (and any drop pulse)
    // occupies the cycle whose count is PERIOD-1.
    always_comb begin
        cnt_d = '0;
        if (en) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        attempt = en && (cnt_d == CNT_LAST);

        state_d      = state_q;
        fill_idx_d   = fill_idx_q;
        push         = 1'b0;
        frame_drop_d = attempt && !(state_q == ST_IDLE && fifo_empty);

        case (state_q)
            ST_IDLE: begin
                if (attempt && fifo_empty) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: state_d = ST_WAIT;
            ST_WAIT: begin
                state_d    = ST_FILL;
                fill_idx_d = '0;
            end
            ST_FILL: begin
                push       = 1'b1;
                fill_idx_d = fill_idx_q + IW'(1);
                if (fill_idx_q == BIN_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter and controller registers.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            fill_idx_q   <= '0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fill_idx_q   <= fill_idx_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    // Record written for the bin currently at the head of the FFT chain.
    always_comb begin
        wr_rec              = '0;
        wr_rec.data[RN-1:0] = fft_data;
        wr_rec.idx[IW-1:0]  = fill_idx_q;
        wr_rec.sof          = (fill_idx_q == '0);
        wr_rec.eof          = (fill_idx_q == BIN_LAST);
    end

    fft_scan_fifo #(
        .RN   (RN),
        .SIZE (SIZE)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .wr_rec  (wr_rec),
        .pop     (pop),
        .rd_rec  (rd_rec),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Capture can only start on an empty buffer, so full is never hit here.
    assign unused_top = ^{rd_rec, fifo_full};

    assign shift      = (state_q != ST_CAPTURE);
    assign busy       = (state_q != ST_IDLE);
    assign frame_drop = frame_drop_q;
    assign bin_valid  = !fifo_empty;
    assign pop        = bin_valid && bin_ready;
    assign bin_data   = rd_rec.data[RN-1:0];
    assign bin_idx    = rd_rec.idx[IW-1:0];
    assign bin_sof    = rd_rec.sof;
    assign bin_eof    = rd_rec.eof;

`ifdef FFT_SCAN_PEAK_EN
    logic [RN-1:0] run_val_q, run_val_d;
    logic [IW-1:0] run_idx_q, run_idx_d;
    logic [RN-1:0] peak_val_q, peak_val_d;
    logic [IW-1:0] peak_idx_q, peak_idx_d;
    logic          peak_valid_q, peak_valid_d;

    // Running maximum over FILL; strict compare keeps the lowest index on
    // ties. The result is published after the last bin and held.
    always_comb begin
        run_val_d    = run_val_q;
        run_idx_d    = run_idx_q;
        peak_val_d   = peak_val_q;
        peak_idx_d   = peak_idx_q;
        peak_valid_d = 1'b0;
        if (state_q == ST_FILL) begin
            if (fill_idx_q == '0 || fft_data > run_val_q) begin
                run_val_d = fft_data;
                run_idx_d = fill_idx_q;
            end
            if (fill_idx_q == BIN_LAST) begin
                peak_val_d   = run_val_d;
                peak_idx_d   = run_idx_d;
                peak_valid_d = 1'b1;
            end
        end
    end

    // Peak tracker registers.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            run_val_q    <= '0;
            run_idx_q    <= '0;
            peak_val_q   <= '0;
            peak_idx_q   <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            run_val_q    <= run_val_d;
            run_idx_q    <= run_idx_d;
            peak_val_q   <= peak_val_d;
            peak_idx_q   <= peak_idx_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign peak_val   = peak_val_q;
    assign peak_idx   = peak_idx_q;
    assign peak_valid = peak_valid_q;
`endif

endmodule

// File: tb/tb_fft_scan.sv
// Directed bench for fft_scan with SIZE=8, RN=16, PERIOD=32.
// Cycle numbering: cycle 0 is the first cycle after reset release with en=1,
// so the period counter reads c during cycle c (mod 32).
module tb_fft_scan;

    localparam int RN     = 16;
    localparam int SIZE   = 8;
    localparam int PERIOD = 32;
    localparam int IW     = 3;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          en;
    logic          shift;
    logic [RN-1:0] fft_data;
    logic [RN-1:0] bin_data;
    logic [IW-1:0] bin_idx;
    logic          bin_sof, bin_eof, bin_valid, bin_ready;
    logic          frame_drop, busy;
`ifdef FFT_SCAN_PEAK_EN
    logic [RN-1:0] peak_val;
    logic [IW-1:0] peak_idx;
    logic          peak_valid;
`endif

    always #5 clk = ~clk;

    fft_scan #(.RN(RN), .SIZE(SIZE), .PERIOD(PERIOD)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .en         (en),
        .shift      (shift),
        .fft_data   (fft_data),
        .bin_data   (bin_data),
        .bin_idx    (bin_idx),
        .bin_sof    (bin_sof),
        .bin_eof    (bin_eof),
        .bin_valid  (bin_valid),
        .bin_ready  (bin_ready),
        .frame_drop (frame_drop),
        .busy       (busy)
`ifdef FFT_SCAN_PEAK_EN
        ,
        .peak_val   (peak_val),
        .peak_idx   (peak_idx),
        .peak_valid (peak_valid)
`endif
    );

    // One table row: the value the FFT presents for bin k and the record the
    // stream must deliver for it.
    typedef struct {
        int fft_in;
        int exp_data;
        int exp_idx;
        int exp_sof;
        int exp_eof;
    } vec_t;

    typedef struct {
        int data;
        int idx;
        int sof;
        int eof;
    } bin_t;

    vec_t cnt_vec  [SIZE];
    vec_t peak_vec [SIZE];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc;
    int   data_mode;
    bin_t got_q[$];
    int   shift_low_q[$];
    int   drop_q[$];
    int   peakv_q[$];
    int   busy_cnt;
    int   unstable;
    int   first_valid;
    bit   hold_prev;
    bin_t prev_bin;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic int fd_value(input int c);
        if (data_mode == 1) begin
            if (c >= 33 && c <= 40) return peak_vec[c-33].fft_in;
            return 50;
        end
        return c & 16'hffff;
    endfunction

    task automatic clear_obs();
        got_q.delete();
        shift_low_q.delete();
        drop_q.delete();
        peakv_q.delete();
        busy_cnt    = 0;
        unstable    = 0;
        first_valid = -1;
        hold_prev   = 1'b0;
    endtask

    // Reset with en low, then release with en high: the caller is in cycle 0.
    task automatic do_reset();
        n_reset   = 1'b0;
        en        = 1'b0;
        bin_ready = 1'b0;
        fft_data  = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        n_reset = 1'b1;
        en      = 1'b1;
        cyc     = 0;
        clear_obs();
    endtask

    // Run n cycles. ready_mode: 0 never ready, 1 always ready, 2 ready on
    // even cycles. Observations are taken mid-cycle.
    task automatic run(input int n, input int ready_mode);
        bin_t cur;
        for (int i = 0; i < n; i++) begin
            fft_data  = RN'(fd_value(cyc));
            bin_ready = (ready_mode == 1) || (ready_mode == 2 && cyc % 2 == 0);
            #3;
            cur = '{int'(bin_data), int'(bin_idx), int'(bin_sof), int'(bin_eof)};
            if (!shift) shift_low_q.push_back(cyc);
            if (frame_drop) drop_q.push_back(cyc);
            if (busy) busy_cnt++;
            if (bin_valid && first_valid < 0) first_valid = cyc;
            if (hold_prev && cur != prev_bin) unstable++;
            hold_prev = bin_valid && !bin_ready;
            prev_bin  = cur;
            if (bin_valid && bin_ready) got_q.push_back(cur);
`ifdef FFT_SCAN_PEAK_EN
            if (peak_valid) peakv_q.push_back(cyc);
`endif
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic compare_bins(input string tag, input int use_peak);
        vec_t ev;
        check({tag, " bin count"}, got_q.size(), SIZE);
        for (int k = 0; k < got_q.size() && k < SIZE; k++) begin
            ev = (use_peak != 0) ? peak_vec[k] : cnt_vec[k];
            check($sformatf("%s bin%0d data", tag, k), got_q[k].data, ev.exp_data);
            check($sformatf("%s bin%0d idx", tag, k), got_q[k].idx, ev.exp_idx);
            check($sformatf("%s bin%0d sof", tag, k), got_q[k].sof, ev.exp_sof);
            check($sformatf("%s bin%0d eof", tag, k), got_q[k].eof, ev.exp_eof);
        end
    endtask

    task automatic check_single_capture(input string tag);
        check({tag, " shift-low count"}, shift_low_q.size(), 1);
        if (shift_low_q.size() > 0) check({tag, " shift-low cycle"}, shift_low_q[0], 31);
    endtask

    initial begin
        int pk[SIZE] = '{5, 9, 2, 9, 1, 0, 3, 4};
        for (int k = 0; k < SIZE; k++) begin
            cnt_vec[k]  = '{33 + k, 33 + k, k, int'(k == 0), int'(k == SIZE-1)};
            peak_vec[k] = '{pk[k], pk[k], k, int'(k == 0), int'(k == SIZE-1)};
        end
        data_mode = 0;

        // Reset values.
        do_reset();
        check("rst shift", int'(shift), 1);
        check("rst bin_valid", int'(bin_valid), 0);
        check("rst frame_drop", int'(frame_drop), 0);
        check("rst busy", int'(busy), 0);
        check("rst bin_data", int'(bin_data), 0);
        check("rst bin_idx", int'(bin_idx), 0);
        check("rst sof", int'(bin_sof), 0);
        check("rst eof", int'(bin_eof), 0);
`ifdef FFT_SCAN_PEAK_EN
        check("rst peak_val", int'(peak_val), 0);
        check("rst peak_idx", int'(peak_idx), 0);
        check("rst peak_valid", int'(peak_valid), 0);
`endif

        // Basic frame, always ready.
        release_reset();
        run(46, 1);
        check_single_capture("basic");
        check("basic busy cycles", busy_cnt, 10);
        check("basic drops", drop_q.size(), 0);
        check("basic first valid", first_valid, 34);
        compare_bins("basic", 0);

        // Sink stalled for 100 cycles: later attempts dropped, bins held.
        do_reset();
        release_reset();
        run(100, 0);
        check_single_capture("stall");
        check("stall drop count", drop_q.size(), 2);
        if (drop_q.size() > 0) check("stall drop0 cycle", drop_q[0], 63);
        if (drop_q.size() > 1) check("stall drop1 cycle", drop_q[1], 95);
        check("stall held stable", unstable, 0);
        check("stall head valid", int'(bin_valid), 1);
        check("stall head data", int'(bin_data), 33);
        check("stall head idx", int'(bin_idx), 0);
        got_q.delete();
        run(10, 1);
        compare_bins("stall drain", 0);
        check("stall drained", int'(bin_valid), 0);

        // Reset while bin 3 is being written.
        do_reset();
        release_reset();
        run(36, 0);
        check("midfill partial valid", int'(bin_valid), 1);
        n_reset  = 1'b0;
        fft_data = RN'(fd_value(cyc));
        @(posedge clk);
        #1;
        check("midfill rst valid", int'(bin_valid), 0);
        check("midfill rst busy", int'(busy), 0);
        check("midfill rst shift", int'(shift), 1);
        release_reset();
        run(46, 1);
        check("midfill first valid", first_valid, 34);
        check_single_capture("midfill");
        compare_bins("midfill", 0);

        // Ready toggling every cycle.
        do_reset();
        release_reset();
        run(60, 2);
        check("toggle held stable", unstable, 0);
        compare_bins("toggle", 0);

`ifdef FFT_SCAN_PEAK_EN
        // Peak search with a tie at bins 1 and 3.
        do_reset();
        release_reset();
        data_mode = 1;
        run(46, 1);
        data_mode = 0;
        compare_bins("peak", 1);
        check("peak_valid pulses", peakv_q.size(), 1);
        if (peakv_q.size() > 0) check("peak_valid cycle", peakv_q[0], 41);
        check("peak_val", int'(peak_val), 9);
        check("peak_idx", int'(peak_idx), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
